// File: rtl/uart_rx_fifo.sv
// 16x-oversampling 8N1 UART receiver feeding a small show-ahead FIFO.
// Optional 8E1 framing with even-parity check when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_done,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [TW-1:0] tick_cnt_reg;
  logic          tick;
  logic          rx_meta_reg;
  logic          rx_sync_reg;

  state_t        state_reg, state_next;
  logic [3:0]    samp_reg, samp_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          sample_bit;
  logic          push_req;
  logic          frame_bad;
  logic          mid_tick, last_tick;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          do_push, do_pop;

  // Free-running baud tick; receiver phase is tracked by samp_reg instead
  assign tick = (tick_cnt_reg == TW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  assign mid_tick  = tick && (samp_reg == 4'd7);
  assign last_tick = tick && (samp_reg == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_reg;
  logic sample_par;
  logic par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (sample_par) begin
      par_reg <= rx_sync_reg;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    samp_next  = samp_reg;
    bit_next   = bit_reg;
    sample_bit = 1'b0;
    push_req   = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par = 1'b0;
    par_bad    = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!rx_sync_reg) begin
          state_next = ST_START;
          samp_next  = 4'd0;
        end
      end
      ST_START: begin
        if (tick) samp_next = samp_reg + 4'd1;
        if (mid_tick) begin
          if (rx_sync_reg) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            bit_next   = 3'd0;
            samp_next  = 4'd0;
          end
        end
      end
      ST_DATA: begin
        if (tick) samp_next = samp_reg + 4'd1;
        if (last_tick) begin
          sample_bit = 1'b1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) samp_next = samp_reg + 4'd1;
        if (last_tick) begin
          sample_par = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) samp_next = samp_reg + 4'd1;
        if (last_tick) begin
          state_next = ST_IDLE;
          if (!rx_sync_reg) begin
            frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{par_reg, shift_reg}) begin
            par_bad = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      samp_reg  <= 4'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      samp_reg  <= samp_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (sample_bit && (bit_reg == 3'(gi))) ? rx_sync_reg : shift_reg[gi];
    end
  endgenerate

  // A pop frees the slot a full-FIFO push needs in the same cycle
  assign do_pop  = rd_en && !empty;
  assign do_push = push_req && (!full || do_pop);

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign rd_data = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
      rx_done   <= do_push;
      frame_err <= frame_bad;
      overflow  <= push_req && !do_push;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus a randomized
// frame/pop sequence checked against a queue model of the FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 4;
  localparam int BITC     = 160;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA    = BITC;
`else
  localparam int EXTRA    = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       rd_man = 1'b0;
  logic       rd_auto = 1'b0;
  logic       arm_auto = 1'b0;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [2:0] count;
  logic       rx_done, frame_err, overflow, parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = 0;
  int n_done = 0, n_ferr = 0, n_ovf = 0, n_perr = 0;

  assign rd_en = rd_man | rd_auto;

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      n_done <= n_done + 1;
      last_done_cyc <= cyc;
    end
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (overflow)   n_ovf  <= n_ovf + 1;
    if (parity_err) n_perr <= n_perr + 1;
    rd_auto <= arm_auto && dut.push_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    idle(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BITC);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ !par_ok;
    idle(BITC);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      idle(BITC);
    end else begin
      // bad stop bit low through its middle only, so no spurious start follows
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(BITC - 100);
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rd_man = 1'b1;
    @(negedge clk);
    rd_man = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_pulses"}, 32'({rx_done, frame_err, overflow, parity_err}), 32'd0);
  endtask

  initial begin
    int d0, f0, o0, p0, lat;
    logic [7:0] q[$];
    logic [7:0] d;
    bit stop_ok, par_ok;

    // reset
    #3 rst_n = 1'b0;
    idle(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(20);
    $display("step reset: done");

    // 1: single good frame
    d0 = n_done;
    send_frame(8'hA5, 1'b1, 1'b1);
    lat = last_done_cyc - start_cyc;
    check("t1_done_cnt", 32'(n_done - d0), 32'd1);
    check("t1_latency_window", 32'((lat >= 1500 + EXTRA) && (lat <= 1610 + EXTRA)), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_rd_data", 32'(rd_data), 32'hA5);
    check("t1_count", 32'(count), 32'd1);
    pop();
    check("t1_empty_after_pop", 32'(empty), 32'd1);
    check("t1_count_after_pop", 32'(count), 32'd0);
    $display("step 1: frame 0xA5 latency=%0d", lat);

    // 2: glitch then good frame
    d0 = n_done; f0 = n_ferr; o0 = n_ovf;
    @(negedge clk);
    rx = 1'b0;
    idle(30);
    rx = 1'b1;
    idle(3 * BITC);
    check("t2_glitch_pulses", 32'((n_done - d0) + (n_ferr - f0) + (n_ovf - o0)), 32'd0);
    check("t2_glitch_empty", 32'(empty), 32'd1);
    send_frame(8'h3C, 1'b1, 1'b1);
    check("t2_done_cnt", 32'(n_done - d0), 32'd1);
    check("t2_rd_data", 32'(rd_data), 32'h3C);
    pop();
    $display("step 2: glitch ignored, frame 0x3C");

    // 3: framing error
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(BITC);
    check("t3_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    check("t3_done_cnt", 32'(n_done - d0), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);
    $display("step 3: frame_err on bad stop");

    // 4a: overflow on the fifth back-to-back frame
    d0 = n_done; o0 = n_ovf;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    idle(BITC);
    check("t4a_done_cnt", 32'(n_done - d0), 32'd4);
    check("t4a_ovf_cnt", 32'(n_ovf - o0), 32'd1);
    check("t4a_full", 32'(full), 32'd1);
    check("t4a_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("t4a_read", 32'(rd_data), 32'(i));
      pop();
    end
    check("t4a_empty", 32'(empty), 32'd1);
    $display("step 4a: overflow drop, reads 01..04");

    // 4b: pop coincident with the fifth push
    d0 = n_done; o0 = n_ovf;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) arm_auto = 1'b1;
      send_frame(8'(i), 1'b1, 1'b1);
    end
    arm_auto = 1'b0;
    idle(BITC);
    check("t4b_done_cnt", 32'(n_done - d0), 32'd5);
    check("t4b_ovf_cnt", 32'(n_ovf - o0), 32'd0);
    check("t4b_count", 32'(count), 32'd4);
    check("t4b_full", 32'(full), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      check("t4b_read", 32'(rd_data), 32'(i));
      pop();
    end
    check("t4b_empty", 32'(empty), 32'd1);
    $display("step 4b: simultaneous push/pop, reads 02..05");

    // 5: reset in the middle of a frame
    send_frame(8'h11, 1'b1, 1'b1);
    check("t5_pre_count", 32'(count), 32'd1);
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        idle(720);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        idle(5);
        rst_n = 1'b1;
      end
    join
    d0 = n_done; f0 = n_ferr;
    idle(BITC);
    check("t5_post_empty", 32'(empty), 32'd1);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("t5_done_cnt", 32'(n_done - d0), 32'd1);
    check("t5_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    check("t5_rd_data", 32'(rd_data), 32'h5A);
    check("t5_count", 32'(count), 32'd1);
    pop();
    $display("step 5: mid-frame reset, frame 0x5A");

    // 6: parity
`ifdef UART_RX_PARITY_EN
    d0 = n_done; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    check("t6_perr_cnt", 32'(n_perr - p0), 32'd1);
    check("t6_bad_done", 32'(n_done - d0), 32'd0);
    check("t6_bad_empty", 32'(empty), 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    check("t6_done_cnt", 32'(n_done - d0), 32'd1);
    check("t6_rd_data", 32'(rd_data), 32'h07);
    pop();
    $display("step 6: parity error and good parity frame");
`else
    check("t6_parity_quiet", 32'(n_perr), 32'd0);
    $display("step 6: parity_err stays low");
`endif

    // randomized frames against a queue model
    for (int k = 0; k < 12; k++) begin
      int e_done, e_ferr, e_ovf, e_perr, npop;
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok = ($urandom_range(0, 5) != 0);
`else
      par_ok = 1'b1;
`endif
      d0 = n_done; f0 = n_ferr; o0 = n_ovf; p0 = n_perr;
      e_done = 0; e_ferr = 0; e_ovf = 0; e_perr = 0;
      send_frame(d, stop_ok, par_ok);
      idle(BITC);
      if (!stop_ok) e_ferr = 1;
      else if (!par_ok) e_perr = 1;
      else if (q.size() < DEPTH) begin
        q.push_back(d);
        e_done = 1;
      end else e_ovf = 1;
      check("rnd_done", 32'(n_done - d0), 32'(e_done));
      check("rnd_ferr", 32'(n_ferr - f0), 32'(e_ferr));
      check("rnd_ovf", 32'(n_ovf - o0), 32'(e_ovf));
      check("rnd_perr", 32'(n_perr - p0), 32'(e_perr));
      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_full", 32'(full), 32'(q.size() == DEPTH));
      check("rnd_empty", 32'(empty), 32'(q.size() == 0));
      if (q.size() > 0) check("rnd_head", 32'(rd_data), 32'(q[0]));
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        if (q.size() > 0) begin
          check("rnd_pop_data", 32'(rd_data), 32'(q[0]));
          void'(q.pop_front());
        end
        pop();
        check("rnd_pop_count", 32'(count), 32'(q.size()));
      end
      $display("rnd frame %0d: data=0x%02h stop_ok=%0d par_ok=%0d model_size=%0d", k, d, stop_ok, par_ok, q.size());
    end
    while (q.size() > 0) begin
      check("drain_data", 32'(rd_data), 32'(q[0]));
      void'(q.pop_front());
      pop();
    end
    check("drain_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
